countdown_timer: RTL

Loadable, prescaled down-counter timer. It is the counterpart of the free-running up counter in the common library: it counts a programmed value down to zero, signals expiry with a one-cycle done pulse and can optionally auto-reload. It sits beside the common counter and is used for timeouts, periodic ticks and delay generation by higher-level control blocks.

---
 rtl/countdown_timer.sv | 98 +++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable, prescaled down-counter timer with optional auto-reload
// Counts a loaded value to zero at one step per prescale_i+1 cycles and pulses done_o at expiry.
module countdown_timer #(
  parameter int COUNTER_WIDTH  = 8,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      load_i,
  input  logic [COUNTER_WIDTH-1:0]  load_val_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      auto_reload_i,
  output logic [COUNTER_WIDTH-1:0]  count_o,
  output logic                      busy_o,
  output logic                      done_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE = COUNTER_WIDTH'(1);

  state_e                      state_q,  state_d;
  logic [COUNTER_WIDTH-1:0]    count_q,  count_d;
  logic [COUNTER_WIDTH-1:0]    reload_q, reload_d;
  logic [PRESCALE_WIDTH-1:0]   presc_q,  presc_d;
  logic                        done_q,   done_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    done_d   = 1'b0;

    if (stop_i) begin
      state_d = IDLE;
      presc_d = '0;
    end else if (load_i) begin
      count_d  = load_val_i;
      reload_d = load_val_i;
      presc_d  = '0;
    end else if (start_i && (state_q == IDLE)) begin
      if (count_q != '0) begin
        state_d = RUN;
        presc_d = '0;
      end else begin
        done_d = 1'b1;
      end
    end else if (state_q == RUN) begin
      // >= rather than == so lowering prescale_i mid-period cannot skip the tick
      if (presc_q >= prescale_i) begin
        presc_d = '0;
        if (count_q > COUNT_ONE) begin
          count_d = count_q - COUNT_ONE;
        end else if (count_q == COUNT_ONE) begin
          done_d = 1'b1;
          if (auto_reload_i && (reload_q != '0)) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = IDLE;
          end
        end else begin
          // Only reachable after loading 0 while running: drop back quietly, never underflow
          state_d = IDLE;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      presc_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
    end
  end

  assign count_o = count_q;
  assign busy_o  = (state_q == RUN);
  assign done_o  = done_q;

endmodule
